// File: rtl/aes_cipher_round128.sv
// Iterative AES-128 encryption core: one round per clock, with the round key
// streamed in on Wk0..Wk3 by a key expander that shares the same ld strobe.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign d = SBOX[a];
endmodule

module aes_cipher_round128 (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ld,
    input  logic [127:0] TEXT_IN,
    input  logic [31:0]  Wk0,
    input  logic [31:0]  Wk1,
    input  logic [31:0]  Wk2,
    input  logic [31:0]  Wk3,
    output logic [127:0] TEXT_OUT,
    output logic         done,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, ARK, ROUND, FINAL, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] text_q, text_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic         done_q, busy_q;

    logic [127:0] wk, sb, sr;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block sits at bits [127-8k -: 8]; k = 4*column + row.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) a[rw] = s[127-8*(4*c+rw) -: 8];
            for (int rw = 0; rw < 4; rw++)
                r[127-8*(4*c+rw) -: 8] = xtime(a[rw]) ^ xtime(a[(rw+1)%4]) ^ a[(rw+1)%4]
                                         ^ a[(rw+2)%4] ^ a[(rw+3)%4];
        end
        return r;
    endfunction

    assign wk = {Wk0, Wk1, Wk2, Wk3};

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (.a(st_q[127-8*i -: 8]), .d(sb[127-8*i -: 8]));
    end

    assign sr = shift_rows(sb);

    // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        text_d  = text_q;
        st_d    = st_q;
        out_d   = out_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            IDLE: begin
                if (ld) begin
                    text_d  = TEXT_IN;
                    state_d = ARK;
                end
            end
            ARK, ROUND, FINAL: begin
                if (ld) begin
                    // Restart in lockstep with the key expander, which reloads on the same strobe.
                    text_d  = TEXT_IN;
                    rcnt_d  = 4'd0;
                    state_d = ARK;
                end else if (state_q == ARK) begin
                    st_d    = text_q ^ wk;
                    rcnt_d  = 4'd1;
                    state_d = ROUND;
                end else if (state_q == ROUND) begin
                    st_d    = mix_columns(sr) ^ wk;
                    rcnt_d  = (rcnt_q == 4'hf) ? rcnt_q : rcnt_q + 4'd1;
                    if (rcnt_q == 4'd9) state_d = FINAL;
                end else begin
                    out_d   = sr ^ wk;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (ld) begin
                    text_d  = TEXT_IN;
                    state_d = ARK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            text_q  <= '0;
            st_q    <= '0;
            out_q   <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            st_q    <= st_d;
            out_q   <= out_d;
            rcnt_q  <= rcnt_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign TEXT_OUT = out_q;
    assign done     = done_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_aes_cipher_round128.sv
// Bench for aes_cipher_round128: models the key expander on the shared ld and
// compares against an arithmetic AES-128 reference (S-box built from GF inverses).

module tb_aes_cipher_round128;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ld  = 1'b0;
    logic [127:0] TEXT_IN = '0;
    logic [31:0]  Wk0 = '0, Wk1 = '0, Wk2 = '0, Wk3 = '0;
    logic [127:0] TEXT_OUT;
    logic         done, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]    sb_tab [256];
    logic [1407:0] kw_flat;
    logic [127:0]  pend_key = '0;
    logic [127:0]  last_ct = '0;
    int            kidx = -1;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_cipher_round128 dut (
        .CLK(CLK), .RST(RST), .ld(ld), .TEXT_IN(TEXT_IN),
        .Wk0(Wk0), .Wk1(Wk1), .Wk2(Wk2), .Wk3(Wk3),
        .TEXT_OUT(TEXT_OUT), .done(done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00, aa = x, bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] f;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) f[1407-32*i -: 32] = w[i];
        return f;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] ks;
        logic [7:0]    s [4][4];
        logic [7:0]    t [4][4];
        logic [31:0]   w;
        logic [127:0]  ct;
        ks = expand(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8];
        for (int rnd = 0; rnd <= 10; rnd++) begin
            if (rnd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sb_tab[s[r][(c+r)%4]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[r][c] = (rnd == 10) ? t[r][c] :
                                  gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03)
                                  ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
            end
            for (int c = 0; c < 4; c++) begin
                w = ks[1407-32*(4*rnd+c) -: 32];
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
        return ct;
    endfunction

    // ---------------- key expander model ----------------
    always @(posedge CLK) begin
        if (RST) kidx = -1;
        else if (ld) begin
            kw_flat = expand(pend_key);
            kidx = 0;
        end else if (kidx >= 0 && kidx < 10) kidx++;
        else kidx = -1;
        #1;
        if (kidx >= 0) {Wk0, Wk1, Wk2, Wk3} = kw_flat[1407-128*kidx -: 128];
        else {Wk0, Wk1, Wk2, Wk3} = {$urandom, $urandom, $urandom, $urandom};
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_ld(input logic [127:0] key, input logic [127:0] pt);
        ld = 1'b1;
        TEXT_IN = pt;
        pend_key = key;
    endtask

    // Caller raises ld at a negedge (cycle 0); checks cycles 1..12 of the block.
    task automatic run_block(input string name, input logic [127:0] exp_ct, input bit chain,
                             input logic [127:0] nkey, input logic [127:0] npt);
        @(negedge CLK);
        ld = 1'b0;
        TEXT_IN = rand128();
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL %s busy c%0d: got %b want 1", name, c, busy); end
            checks++;
            if (done !== (c == 12)) begin errors++; $display("FAIL %s done c%0d: got %b want %b", name, c, done, c == 12); end
            if (c < 12) begin
                checks++;
                if (TEXT_OUT !== last_ct) begin errors++; $display("FAIL %s hold c%0d: got %h want %h", name, c, TEXT_OUT, last_ct); end
                @(negedge CLK);
            end else begin
                checks++;
                if (TEXT_OUT !== exp_ct) begin errors++; $display("FAIL %s ct: got %h want %h", name, TEXT_OUT, exp_ct); end
                last_ct = exp_ct;
                if (chain) drive_ld(nkey, npt);
            end
        end
        if (!chain) begin
            @(negedge CLK);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL %s post: got busy=%b done=%b want 0 0", name, busy, done);
            end
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || TEXT_OUT !== last_ct) begin
                errors++;
                $display("FAIL %s idle c%0d: got busy=%b done=%b out=%h want 0 0 %h", name, c, busy, done, TEXT_OUT, last_ct);
            end
            @(negedge CLK);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (TEXT_OUT !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset: got out=%h done=%b busy=%b want 0 0 0", TEXT_OUT, done, busy);
        end
        RST = 1'b0;
        last_ct = '0;
        @(negedge CLK);
    endtask

    task automatic test_fips_b();
        checks++;
        if (ref_encrypt(KEY_B, PT_B) !== CT_B) begin errors++; $display("FAIL model_b: got %h want %h", ref_encrypt(KEY_B, PT_B), CT_B); end
        drive_ld(KEY_B, PT_B);
        run_block("fips_b", CT_B, 1'b0, '0, '0);
    endtask

    task automatic test_fips_c1_hold();
        drive_ld(KEY_C, PT_C);
        run_block("fips_c1", CT_C, 1'b0, '0, '0);
        expect_idle("c1_hold", 20);
    endtask

    task automatic test_back_to_back();
        drive_ld(KEY_B, PT_B);
        run_block("b2b_1", CT_B, 1'b1, KEY_C, PT_C);
        run_block("b2b_2", CT_C, 1'b0, '0, '0);
    endtask

    task automatic test_abort();
        drive_ld(KEY_C, PT_C);
        @(negedge CLK);
        ld = 1'b0;
        TEXT_IN = rand128();
        for (int c = 1; c < 6; c++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || TEXT_OUT !== last_ct) begin
                errors++; $display("FAIL abort pre c%0d: got done=%b busy=%b out=%h", c, done, busy, TEXT_OUT);
            end
            @(negedge CLK);
        end
        drive_ld(KEY_B, PT_B);
        run_block("abort", CT_B, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        drive_ld(rand128(), rand128());
        @(negedge CLK);
        ld = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (TEXT_OUT !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got out=%h done=%b busy=%b want 0 0 0", TEXT_OUT, done, busy);
        end
        RST = 1'b0;
        last_ct = '0;
        expect_idle("rst_mid", 15);
        drive_ld(KEY_C, PT_C);
        run_block("after_rst", CT_C, 1'b0, '0, '0);
    endtask

    task automatic test_rst_and_ld();
        RST = 1'b1;
        drive_ld(KEY_B, PT_B);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_ld: got busy=%b done=%b want 0 0", busy, done);
        end
        RST = 1'b0;
        ld = 1'b0;
        last_ct = '0;
        expect_idle("rst_ld", 14);
    endtask

    task automatic test_random_chain();
        logic [127:0] k [5];
        logic [127:0] p [5];
        for (int i = 0; i < 5; i++) begin k[i] = rand128(); p[i] = rand128(); end
        drive_ld(k[0], p[0]);
        for (int i = 0; i < 4; i++)
            run_block($sformatf("rand%0d", i), ref_encrypt(k[i], p[i]), 1'b1, k[i+1], p[i+1]);
        run_block("rand4", ref_encrypt(k[4], p[4]), 1'b0, '0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
        test_reset();
        test_fips_b();
        test_fips_c1_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_rst_and_ld();
        test_random_chain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_cipher_round128.md
Name: aes_cipher_round128

Overview:
- Iterative AES-128 encryption datapath that consumes the four round-key words produced each cycle by the 128-bit key expander.
- Shares the `ld` strobe with the key expander so that round key i arrives on Wk0..Wk3 exactly when round i is computed.
- Performs initial AddRoundKey, 9 full rounds and a final round (no MixColumns), one round per clock.
- Presents the ciphertext with a one-cycle `done` pulse; sits directly downstream of the key expander inside the CMAC engine.

Parameters:
- None.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- ld  input  1  start strobe; same signal that drives the key expander `ld`.
- TEXT_IN  input  128  plaintext block; bits [127:120] are byte 0 (FIPS-197 column-major order).
- Wk0  input  32  round-key word 0 (bits [127:96] of the round key).
- Wk1  input  32  round-key word 1.
- Wk2  input  32  round-key word 2.
- Wk3  input  32  round-key word 3.
- TEXT_OUT  output  128  ciphertext register.
- done  output  1  one-cycle pulse, high when TEXT_OUT has just been updated.
- busy  output  1  high from the cycle after `ld` until `done`, inclusive.

Behaviour:
- Reset: RST sampled high forces the following, regardless of ld:
  - FSM to IDLE;
  - TEXT_OUT=0, done=0, busy=0;
  - internal text/state registers and round counter to 0.
- Timing anchor: call the cycle in which ld is sampled high cycle 0. The key expander then shows K0 in cycle 1, K1 in cycle 2, …, K10 in cycle 11.
- FSM states: IDLE, ARK, ROUND, FINAL, DONE.
- IDLE, ld=1: text_r <= TEXT_IN; go to ARK.
- ARK (cycle 1):
  - state <= text_r ^ {Wk0,Wk1,Wk2,Wk3};
  - rcnt <= 1; go to ROUND.
- ROUND (cycles 2..10):
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ Wk;
  - rcnt increments;
  - when rcnt==9 in this state, go to FINAL.
- FINAL (cycle 11):
  - TEXT_OUT <= ShiftRows(SubBytes(state)) ^ Wk;
  - go to DONE.
- DONE (cycle 12):
  - done=1, busy=1;
  - next state IDLE; if ld=1 in this cycle, text_r <= TEXT_IN and go to ARK (back-to-back blocks).
- done and busy are registered state decodes (Moore). Latency from ld to done is exactly 12 cycles; throughput is one block per 12 cycles.
- TEXT_OUT holds its value until the next FINAL or RST. It is never cleared by ld.
- ld in ARK, ROUND or FINAL is an abort/restart:
  - text_r <= TEXT_IN, rcnt <= 0, go to ARK;
  - no done is generated for the aborted block;
  - TEXT_OUT is unchanged.
  - This matches the key expander, which reloads on the same ld.
- ld while RST=1: ignored.
- SubBytes uses 16 instances of the existing aes_sbox (a in, d out), shared between ROUND and FINAL.
- MixColumns uses GF(2^8) xtime with polynomial 0x11b. Each output byte is 2a^3b^c^d, rotated per row.
- rcnt is 4 bits and saturates; it never wraps within a block.
- Wk is only sampled in ARK, ROUND and FINAL; its value in IDLE/DONE is don't-care.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, driven with key expander on the same ld -> done high exactly 12 cycles after ld, TEXT_OUT=3925841d02dc09fbdc118597196a0b32, busy high cycles 1..12.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> TEXT_OUT=69c4e0d86a7b0430d8cdb78070b4c55a; value held stable for 20 idle cycles afterwards.
- Back-to-back: App. B block, then ld in the done cycle with App. C.1 key/pt -> two done pulses 12 cycles apart with the respective ciphertexts.
- Abort: start App. C.1, reassert ld in cycle 6 with App. B key/pt -> no done at cycle 12; done 12 cycles after the second ld with 3925841d…0b32; TEXT_OUT unchanged in between.
- Reset mid-operation: RST=1 in cycle 5 of a block -> next cycle TEXT_OUT=0, done=0, busy=0; no done ever appears; a fresh ld then completes normally.
- Simultaneous RST and ld -> RST wins; block stays IDLE, busy=0 on the following cycle.
